trace_ctrl: RTL and testbench
=============================

TRACE_CTRL -- requirements
Module: trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, entry count of the controlled trace buffer (power of two, >=4); PTR_BITS = $clog2(DEPTH) derived, not user-set.
REQ-002 SHALL have ports: clk_i  in  1  sole clock, rising edge; rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: arm_i  in  1  start-capture pulse; abort_i  in  1  return-to-idle pulse; trig_event_i  in  1  hardware trigger (exception/interrupt).
REQ-004 SHALL have ports: post_count_i  in  PTR_BITS  retires captured after trigger, sampled on trigger; retire_valid_i  in  1  retired-instr pulse (same signal fed to buffer).
REQ-005 SHALL have ports: drain_req_i  in  1  start-readout pulse; tb_enable_o  out  1  buffer enable; tb_trigger_o  out  1  buffer freeze.
REQ-006 SHALL have ports: tb_wr_ptr_i  in  PTR_BITS  buffer write pointer; tb_rd_addr_o  out  PTR_BITS  buffer read address; tb_rd_pc_i, tb_rd_instr_i  in  32 each  combinational read data.
REQ-007 SHALL have ports: m_valid_o  out  1; m_ready_i  in  1; m_data_o  out  64  {pc,instr}; m_last_o  out  1  final entry.
REQ-008 SHALL have ports: fill_o  out  PTR_BITS+1  valid entries; state_o  out  3  FSM state; done_o  out  1  drain-complete pulse.

Function
REQ-009 SHALL implement FSM IDLE(0), ARMED(1), POST(2), FROZEN(3), DRAIN(4); state_o = encoding.
REQ-010 IDLE: arm_i -> ARMED, fill cleared to 0; all other inputs except abort_i ignored.
REQ-011 tb_enable_o SHALL be 1 exactly in ARMED and POST (decoded from registered state); tb_trigger_o SHALL be 1 exactly in FROZEN and DRAIN.
REQ-012 Capture = tb_enable_o && retire_valid_i; each capture increments fill, saturating at DEPTH.
REQ-013 ARMED: trig_event_i -> POST with counter = post_count_i; if post_count_i == 0 -> FROZEN directly. A capture in the trigger cycle is counted in fill, not in the post counter.
REQ-014 POST: each capture decrements counter; capture with counter == 1 -> FROZEN next cycle; trig_event_i ignored.
REQ-015 FROZEN: drain_req_i -> DRAIN if fill != 0; if fill == 0 stay IDLE-bound: go to IDLE and pulse done_o one cycle, m_valid_o never asserted.
REQ-016 On DRAIN entry tb_rd_addr_o SHALL = (tb_wr_ptr_i - fill) mod DEPTH (oldest entry), wrap-around via PTR_BITS truncation.
REQ-017 DRAIN: output register loads {tb_rd_pc_i, tb_rd_instr_i} when !m_valid_o || m_ready_i; on load tb_rd_addr_o increments modulo DEPTH; first m_valid_o one cycle after DRAIN entry.
REQ-018 m_data_o/m_last_o SHALL hold stable while m_valid_o && !m_ready_i; m_valid_o SHALL not drop without handshake.
REQ-019 Exactly fill entries SHALL be emitted oldest-to-newest; m_last_o = 1 only on the fill-th entry.
REQ-020 Handshake of last entry -> IDLE, m_valid_o = 0 next cycle, done_o pulses one cycle.
REQ-021 abort_i in any state SHALL -> IDLE next cycle, m_valid_o cleared, fill preserved; abort_i has priority over every other input in the same cycle.
REQ-022 arm_i outside IDLE SHALL be ignored.

Reset
REQ-023 rst_i SHALL force state IDLE, fill 0, counter 0, tb_rd_addr_o 0, m_valid_o 0, m_last_o 0, m_data_o 0, done_o 0, tb_enable_o 0, tb_trigger_o 0 on the next rising edge.
REQ-024 rst_i asserted mid-drain SHALL abandon the transfer with no further m_valid_o.

Configuration
REQ-025 Macro TRACE_CTRL_SW_TRIG_EN SHALL, when defined, add input sw_trig_i (1 bit), OR-ed with trig_event_i in ARMED.
REQ-026 Without TRACE_CTRL_SW_TRIG_EN the port SHALL not exist and only trig_event_i triggers.

Verification
REQ-027 DEPTH=8, arm, 3 retires, trig with post_count=2, 5 more retires -> FROZEN after 5th total capture, fill=5, drain yields 5 beats oldest-first, m_last_o on 5th, done_o pulse.
REQ-028 DEPTH=8, tb_wr_ptr_i wraps: 20 captures, post_count=0 -> fill=8, first tb_rd_addr_o = wr_ptr-8 mod 8, 8 beats, addresses wrap 7->0.
REQ-029 Drain with m_ready_i low 4 cycles on beat 2 -> m_data_o stable, no beat lost/duplicated.
REQ-030 abort_i same cycle as trig_event_i in ARMED -> IDLE, tb_enable_o=0 next cycle; abort mid-drain -> m_valid_o 0 next cycle.
REQ-031 drain_req_i with fill=0 -> done_o pulse, no m_valid_o; with/without TRACE_CTRL_SW_TRIG_EN, sw_trig_i in ARMED -> POST only when defined.

Source files
------------

// File: rtl/trace_ctrl.sv
// Trace buffer capture/drain controller: arm, trigger, post-trigger capture, freeze, then stream out.
// Optional macro TRACE_CTRL_SW_TRIG_EN adds a software trigger input sw_trig_i.
module trace_ctrl #(
  parameter int DEPTH = 64,
  localparam int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic                trig_event_i,
`ifdef TRACE_CTRL_SW_TRIG_EN
  input  logic                sw_trig_i,
`endif
  input  logic [PTR_BITS-1:0] post_count_i,
  input  logic                retire_valid_i,
  input  logic                drain_req_i,
  output logic                tb_enable_o,
  output logic                tb_trigger_o,
  input  logic [PTR_BITS-1:0] tb_wr_ptr_i,
  output logic [PTR_BITS-1:0] tb_rd_addr_o,
  input  logic [31:0]         tb_rd_pc_i,
  input  logic [31:0]         tb_rd_instr_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [63:0]         m_data_o,
  output logic                m_last_o,
  output logic [PTR_BITS:0]   fill_o,
  output logic [2:0]          state_o,
  output logic                done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    POST   = 3'd2,
    FROZEN = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  localparam logic [PTR_BITS:0]   FILL_MAX = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS:0]   FILL_ONE = (PTR_BITS+1)'(1);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);

  state_t              state;
  logic [PTR_BITS:0]   fill;
  logic [PTR_BITS:0]   remaining;
  logic [PTR_BITS-1:0] cnt;
  logic [PTR_BITS-1:0] rd_addr;
  logic                m_valid;
  logic                m_last;
  logic [63:0]         m_data;
  logic                done;
  logic                capture;
  logic                trig_any;

`ifdef TRACE_CTRL_SW_TRIG_EN
  assign trig_any = trig_event_i | sw_trig_i;
`else
  assign trig_any = trig_event_i;
`endif

  assign tb_enable_o  = (state == ARMED) || (state == POST);
  assign tb_trigger_o = (state == FROZEN) || (state == DRAIN);
  assign capture      = tb_enable_o && retire_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      fill      <= '0;
      remaining <= '0;
      cnt       <= '0;
      rd_addr   <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_i) begin
        state   <= IDLE;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        // capture is only possible in ARMED/POST, so this never collides with the IDLE clear
        if (capture && (fill != FILL_MAX)) fill <= fill + FILL_ONE;
        case (state)
          IDLE: begin
            if (arm_i) begin
              state <= ARMED;
              fill  <= '0;
            end
          end
          ARMED: begin
            if (trig_any) begin
              cnt   <= post_count_i;
              state <= (post_count_i == '0) ? FROZEN : POST;
            end
          end
          POST: begin
            if (capture) begin
              cnt <= cnt - PTR_ONE;
              if (cnt == PTR_ONE) state <= FROZEN;
            end
          end
          FROZEN: begin
            if (drain_req_i) begin
              if (fill != '0) begin
                state     <= DRAIN;
                rd_addr   <= tb_wr_ptr_i - fill[PTR_BITS-1:0];
                remaining <= fill;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (m_valid && m_ready_i && m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              state   <= IDLE;
              done    <= 1'b1;
            end else if (!m_valid || m_ready_i) begin
              m_data    <= {tb_rd_pc_i, tb_rd_instr_i};
              m_valid   <= 1'b1;
              m_last    <= (remaining == FILL_ONE);
              rd_addr   <= rd_addr + PTR_ONE;
              remaining <= remaining - FILL_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign state_o      = state;
  assign fill_o       = fill;
  assign tb_rd_addr_o = rd_addr;
  assign m_valid_o    = m_valid;
  assign m_last_o     = m_last;
  assign m_data_o     = m_data;
  assign done_o       = done;

endmodule

// File: tb/tb_trace_ctrl.sv
// Scoreboard bench for trace_ctrl with DEPTH=8 and a behavioural trace buffer model.
module tb_trace_ctrl;
  localparam int DEPTH = 8;
  localparam int PB = 3;

  logic clk_i = 1'b0;
  logic rst_i, arm_i, abort_i, trig_event_i, retire_valid_i, drain_req_i, m_ready_i;
  logic sw_trig_i;
  logic [PB-1:0] post_count_i, tb_wr_ptr_i, tb_rd_addr_o;
  logic [31:0] tb_rd_pc_i, tb_rd_instr_i;
  logic tb_enable_o, tb_trigger_o, m_valid_o, m_last_o, done_o;
  logic [63:0] m_data_o;
  logic [PB:0] fill_o;
  logic [2:0] state_o;

  always #5 clk_i = ~clk_i;

  trace_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_event_i(trig_event_i),
`ifdef TRACE_CTRL_SW_TRIG_EN
    .sw_trig_i(sw_trig_i),
`endif
    .post_count_i(post_count_i), .retire_valid_i(retire_valid_i),
    .drain_req_i(drain_req_i), .tb_enable_o(tb_enable_o), .tb_trigger_o(tb_trigger_o),
    .tb_wr_ptr_i(tb_wr_ptr_i), .tb_rd_addr_o(tb_rd_addr_o),
    .tb_rd_pc_i(tb_rd_pc_i), .tb_rd_instr_i(tb_rd_instr_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .fill_o(fill_o), .state_o(state_o), .done_o(done_o)
  );

  // Trace buffer model: entry k carries pc 0x1000+4k and instr 0xA0000000+k
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [PB-1:0] wr_ptr = '0;
  int cap_idx = 0;
  assign tb_wr_ptr_i   = wr_ptr;
  assign tb_rd_pc_i    = pc_mem[tb_rd_addr_o];
  assign tb_rd_instr_i = instr_mem[tb_rd_addr_o];
  always @(posedge clk_i) begin
    if (tb_enable_o && retire_valid_i) begin
      pc_mem[wr_ptr]    <= 32'h1000 + 32'(cap_idx * 4);
      instr_mem[wr_ptr] <= 32'hA000_0000 + 32'(cap_idx);
      wr_ptr  <= wr_ptr + 1'b1;
      cap_idx <= cap_idx + 1;
    end
  end

  typedef struct { logic [63:0] data; logic last; } beat_t;
  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  logic hold_valid = 1'b0;
  logic [63:0] hold_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int k, input logic last);
    beat_t b;
    b.data = {32'h1000 + 32'(k * 4), 32'hA000_0000 + 32'(k)};
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability
  always @(negedge clk_i) begin
    if (hold_valid) begin
      chk("stall_valid", 64'(m_valid_o), 64'd1);
      chk("stall_data", m_data_o, hold_data);
    end
    hold_valid = m_valid_o && !m_ready_i && !abort_i && !rst_i;
    hold_data  = m_data_o;
    if (m_valid_o === 1'b1 && m_ready_i) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got %0h expected no beat", m_data_o);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_data", m_data_o, b.data);
        chk("beat_last", 64'(m_last_o), 64'(b.last));
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i); #1;
      if (done_o) seen = 1;
    end
    chk({name, "_done"}, 64'(seen), 64'd1);
    chk({name, "_valid_off"}, 64'(m_valid_o), 64'd0);
    @(negedge clk_i);
    chk({name, "_done_one"}, 64'(done_o), 64'd0);
    chk({name, "_idle"}, 64'(state_o), 64'd0);
  endtask

  task automatic arm_capture(input int n);
    arm_i = 1'b1; step(); arm_i = 1'b0;
    retire_valid_i = (n > 0);
    repeat (n) step();
    retire_valid_i = 1'b0;
  endtask

  initial begin
    bit hs_seen;
    rst_i = 1'b1; arm_i = 0; abort_i = 0; trig_event_i = 0; sw_trig_i = 0;
    post_count_i = '0; retire_valid_i = 0; drain_req_i = 0; m_ready_i = 1'b1;
    step(); step();
    @(negedge clk_i);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_fill", 64'(fill_o), 64'd0);
    chk("rst_ctl", 64'({tb_enable_o, tb_trigger_o, m_valid_o, m_last_o, done_o}), 64'd0);
    chk("rst_addr_data", {m_data_o[63:3], tb_rd_addr_o}, 64'd0);
    step(); rst_i = 1'b0;

    // Basic run: 3 pre-trigger, post_count=2, 5 retires offered afterwards
    arm_capture(3);
    @(negedge clk_i);
    chk("armed_state", 64'(state_o), 64'd1);
    chk("armed_enable", 64'(tb_enable_o), 64'd1);
    trig_event_i = 1'b1; post_count_i = 3'd2; step(); trig_event_i = 1'b0;
    retire_valid_i = 1'b1; repeat (5) step(); retire_valid_i = 1'b0;
    @(negedge clk_i);
    chk("t1_frozen", 64'(state_o), 64'd3);
    chk("t1_fill", 64'(fill_o), 64'd5);
    chk("t1_enables", 64'({tb_enable_o, tb_trigger_o}), 64'b01);
    for (int k = 0; k < 5; k++) push_beat(k, k == 4);
    step(); drain_req_i = 1'b1; step(); drain_req_i = 1'b0;
    @(negedge clk_i);
    chk("t1_drain", 64'(state_o), 64'd4);
    chk("t1_rd_addr", 64'(tb_rd_addr_o), 64'd0);
    chk("t1_no_early_valid", 64'(m_valid_o), 64'd0);
    hs_seen = 0;
    for (int i = 0; i < 20 && !hs_seen; i++) begin
      @(negedge clk_i); #1;
      if (hs_count >= 1) hs_seen = 1;
    end
    chk("t1_first_hs", 64'(hs_seen), 64'd1);
    step(); m_ready_i = 1'b0;
    repeat (4) step();
    m_ready_i = 1'b1;
    wait_done("t1");

    // Wrap run: 20 captures saturate fill; oldest surviving entry is capture 17
    arm_capture(20);
    trig_event_i = 1'b1; post_count_i = 3'd0; step(); trig_event_i = 1'b0;
    @(negedge clk_i);
    chk("t2_frozen", 64'(state_o), 64'd3);
    chk("t2_fill", 64'(fill_o), 64'd8);
    for (int k = 17; k < 25; k++) push_beat(k, k == 24);
    step(); drain_req_i = 1'b1; step(); drain_req_i = 1'b0;
    @(negedge clk_i);
    chk("t2_rd_addr", 64'(tb_rd_addr_o), 64'd1);
    wait_done("t2");

    // Abort together with trigger keeps fill and wins
    arm_capture(2);
    trig_event_i = 1'b1; abort_i = 1'b1; step(); trig_event_i = 1'b0; abort_i = 1'b0;
    @(negedge clk_i);
    chk("abort_trig_state", 64'(state_o), 64'd0);
    chk("abort_trig_enable", 64'(tb_enable_o), 64'd0);
    chk("abort_trig_fill", 64'(fill_o), 64'd2);

    // Empty drain
    step();
    arm_capture(0);
    trig_event_i = 1'b1; post_count_i = 3'd0; step(); trig_event_i = 1'b0;
    drain_req_i = 1'b1; step(); drain_req_i = 1'b0;
    @(negedge clk_i);
    chk("empty_done", 64'(done_o), 64'd1);
    chk("empty_state", 64'(state_o), 64'd0);
    chk("empty_valid", 64'(m_valid_o), 64'd0);
    @(negedge clk_i);
    chk("empty_done_one", 64'(done_o), 64'd0);

    // Abort mid-drain with a stalled beat
    step();
    arm_capture(3);
    trig_event_i = 1'b1; post_count_i = 3'd0; step(); trig_event_i = 1'b0;
    m_ready_i = 1'b0; drain_req_i = 1'b1; step(); drain_req_i = 1'b0;
    repeat (3) step();
    @(negedge clk_i);
    chk("t5_valid_up", 64'(m_valid_o), 64'd1);
    step(); abort_i = 1'b1; step(); abort_i = 1'b0;
    @(negedge clk_i);
    chk("t5_abort_valid", 64'(m_valid_o), 64'd0);
    chk("t5_abort_state", 64'(state_o), 64'd0);
    chk("t5_abort_fill", 64'(fill_o), 64'd3);

    // Reset mid-drain
    step();
    arm_capture(2);
    trig_event_i = 1'b1; post_count_i = 3'd0; step(); trig_event_i = 1'b0;
    drain_req_i = 1'b1; step(); drain_req_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t6_rst_valid", 64'(m_valid_o), 64'd0);
    chk("t6_rst_fill", 64'(fill_o), 64'd0);
    repeat (3) step();
    @(negedge clk_i);
    chk("t6_stays_quiet", 64'({m_valid_o, state_o}), 64'd0);

    // Software trigger only has effect when the macro is defined
    step();
    arm_capture(0);
    sw_trig_i = 1'b1; post_count_i = 3'd3; step(); sw_trig_i = 1'b0;
    @(negedge clk_i);
`ifdef TRACE_CTRL_SW_TRIG_EN
    chk("sw_trig_state", 64'(state_o), 64'd2);
`else
    chk("sw_trig_state", 64'(state_o), 64'd1);
`endif
    step(); abort_i = 1'b1; step(); abort_i = 1'b0;

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
